// File: rtl/sha3_block_packer.sv
// Packs a 64-bit word stream into 576-bit rate blocks for a one-shot SHA3-512 core.
// Handles final-block padding metadata and the core's one-cycle-late buffer_full.
module sha3_block_packer #(
  parameter int WORD_W     = 64,
  parameter int RATE_WORDS = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WORD_W-1:0]            s_data,
  input  logic                         s_valid,
  input  logic                         s_last,
  input  logic [3:0]                   s_bytes,
  output logic                         s_ready,
  output logic [WORD_W*RATE_WORDS-1:0] in,
  output logic                         in_ready,
  output logic                         is_last,
  output logic [9:0]                   byte_num,
  input  logic                         buffer_full
);

  typedef enum logic [1:0] {FILL, SEND, GAP, DONE} state_t;

  state_t      state_r;
  logic [3:0]  wcnt_r;
  logic        pend_last_r;
  logic [9:0]  pend_bytes_r;
  logic        empty_pend_r;

  logic        accept_s;
  logic [3:0]  nbytes_s;
  logic [63:0] word_s;
  logic [9:0]  total_s;

  // Keep the first n bytes (MSB first) of a word, zero the rest.
  function automatic logic [63:0] mask_word(input logic [63:0] d, input logic [3:0] n);
    logic [63:0] m;
    m = d;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) >= n) begin
        m[63-8*i -: 8] = 8'h00;
      end
    end
    return m;
  endfunction

  // Word acceptance, byte-count clamping and final-word masking.
  always_comb begin
    accept_s = s_valid & s_ready;
    if (s_bytes > 4'd8) begin
      nbytes_s = 4'd8;
    end else begin
      nbytes_s = s_bytes;
    end
    if (s_last) begin
      word_s = mask_word(s_data, nbytes_s);
    end else begin
      word_s = s_data;
    end
    total_s = {3'b000, wcnt_r, 3'b000} + {6'b000000, nbytes_s};
  end

  // Block assembly, hand-off sequencing and registered core-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= FILL;
      wcnt_r       <= 4'd0;
      pend_last_r  <= 1'b0;
      pend_bytes_r <= 10'd0;
      empty_pend_r <= 1'b0;
      in           <= '0;
      in_ready     <= 1'b0;
      is_last      <= 1'b0;
      byte_num     <= 10'd0;
      s_ready      <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          s_ready <= 1'b1;
          if (accept_s) begin
            for (int k = 0; k < RATE_WORDS; k++) begin
              if (wcnt_r == 4'(k)) begin
                in[WORD_W*RATE_WORDS-1-WORD_W*k -: WORD_W] <= word_s;
              end
            end
            wcnt_r <= wcnt_r + 4'd1;
            if (s_last) begin
              // Slots past the last word are already zero: in is cleared before every FILL.
              if (total_s == 10'd72) begin
                pend_last_r  <= 1'b0;
                pend_bytes_r <= 10'd0;
                empty_pend_r <= 1'b1;
              end else begin
                pend_last_r  <= 1'b1;
                pend_bytes_r <= total_s;
                empty_pend_r <= 1'b0;
              end
              state_r <= SEND;
              s_ready <= 1'b0;
            end else if (wcnt_r == 4'd8) begin
              pend_last_r  <= 1'b0;
              pend_bytes_r <= 10'd0;
              state_r      <= SEND;
              s_ready      <= 1'b0;
            end else begin
              state_r <= FILL;
            end
          end else begin
            state_r <= FILL;
          end
        end
        SEND: begin
          s_ready <= 1'b0;
          if (!buffer_full) begin
            in_ready <= 1'b1;
            is_last  <= pend_last_r;
            byte_num <= pend_bytes_r;
            state_r  <= GAP;
          end else begin
            in_ready <= 1'b0;
            is_last  <= 1'b0;
            byte_num <= 10'd0;
          end
        end
        GAP: begin
          in_ready <= 1'b0;
          is_last  <= 1'b0;
          byte_num <= 10'd0;
          if (pend_last_r) begin
            state_r <= DONE;
            s_ready <= 1'b0;
          end else if (empty_pend_r) begin
            in           <= '0;
            pend_last_r  <= 1'b1;
            pend_bytes_r <= 10'd0;
            empty_pend_r <= 1'b0;
            state_r      <= SEND;
            s_ready      <= 1'b0;
          end else begin
            wcnt_r  <= 4'd0;
            in      <= '0;
            state_r <= FILL;
            s_ready <= 1'b1;
          end
        end
        DONE: begin
          in_ready <= 1'b0;
          is_last  <= 1'b0;
          byte_num <= 10'd0;
          s_ready  <= 1'b0;
        end
        default: begin
          state_r  <= DONE;
          in_ready <= 1'b0;
          is_last  <= 1'b0;
          byte_num <= 10'd0;
          s_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sha3_block_packer.md
Name: sha3_block_packer

Overview:
- Upstream feeder for the SHA3-512 core (576-bit rate).
- Accepts the message as a stream of 64-bit words with a valid/ready handshake and packs 9 words into one 576-bit rate block.
- Presents each block to the core on in/in_ready/is_last/byte_num and honours the core's buffer_full back-pressure.
- One-shot: handles one message per reset, matching the core.

Parameters:
- WORD_W, 64, input word width in bits (fixed; other values unsupported).
- RATE_WORDS, 9, words per rate block (576/64).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- s_data  input  64  message word; first message byte in [63:56].
- s_valid  input  1  s_data/s_last/s_bytes valid.
- s_last  input  1  final word of message.
- s_bytes  input  4  valid bytes in final word, 0..8; ignored when s_last=0.
- s_ready  output  1  packer accepts a word this cycle.
- in  output  576  rate block to core; word k at [575-64k -: 64].
- in_ready  output  1  one-cycle pulse: block on in is valid.
- is_last  output  1  block is the final (partial or empty) block.
- byte_num  output  10  message bytes in final block, 0..71.
- buffer_full  input  1  core cannot take a block.

Behaviour:
- Reset (reset=0, async): state=FILL, wcnt=0, in=0, in_ready=0, is_last=0, byte_num=0, s_ready=0 while asserted. Any partial block is discarded.
- States: FILL, SEND, GAP, DONE. s_ready=1 only in FILL.
- FILL:
  - A word is accepted when s_valid & s_ready.
  - Write it to slot wcnt. If s_last, bytes beyond s_bytes are forced to 0.
  - wcnt increments after each accepted word.
  - Non-last word at wcnt=8: go to SEND, pend_last=0.
  - s_last at wcnt=k with total=8k+s_bytes<72: zero slots k+1..8, pend_last=1, byte_num=total, go to SEND.
  - s_last at wcnt=8 with s_bytes=8 (total=72): send the full block with pend_last=0 and set empty_pending=1. The following block is all-zero with is_last=1, byte_num=0.
- SEND:
  - While buffer_full=1, hold; in_ready=0, in stable.
  - When buffer_full=0, assert in_ready for exactly 1 cycle with is_last=pend_last, then go to GAP.
- GAP (1 cycle, mandatory because the core updates buffer_full one cycle late):
  - If the last block was sent, go to DONE.
  - Else if empty_pending: clear in, pend_last=1, byte_num=0, empty_pending=0, go to SEND.
  - Else clear wcnt and in, go to FILL.
- DONE: s_ready=0, in_ready=0; stays until reset. s_valid is ignored.
- is_last and byte_num are 0 whenever in_ready=0. is_last must never be high without in_ready, because the core latches is_last unconditionally.
- in holds its value from the SEND entry cycle through the in_ready pulse.
- in_ready latency: at least 1 cycle after the accepting edge of the block's final word (SEND entry), then the first cycle buffer_full=0.
- Minimum spacing between two in_ready pulses is 2 cycles.
- s_bytes>8 is illegal; it is clamped to 8.
- Reset asserted mid-SEND drops in_ready immediately (async). No pulse is issued for the discarded block.

Test Plan:
- "abc": one beat, s_data=0x616263xx_xxxxxxxx, s_last=1, s_bytes=3, buffer_full=0 -> single in_ready pulse 2 cycles after accept; is_last=1, byte_num=3; in[575:552]=0x616263, all other bits 0; then DONE with s_ready=0.
- Empty message: first beat s_last=1, s_bytes=0 -> one pulse, is_last=1, byte_num=0, in=0.
- 72-byte message: 9 beats, last s_bytes=8 -> pulse 1 with is_last=0 and all 9 words packed, then pulse 2 exactly 2 cycles later with is_last=1, byte_num=0, in=0.
- 80-byte message, buffer_full held 1 for 10 cycles at first SEND -> no in_ready and s_ready=0 during the hold; block 1 pulses on the first low cycle; block 2 has is_last=1, byte_num=8, word 0 = beat 10.
- Reset pulse after 4 accepted words, then "abc" -> no pulse for the discarded words; output identical to the first scenario.
- After DONE, drive s_valid=1 for 20 cycles -> s_ready=0, no further in_ready, is_last stays 0.
